ddc_stream_arbiter: RTL and testbench
=====================================

DDC_STREAM_ARBITER -- requirements
Module: ddc_stream_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 128: width of each expanded IQ stream beat (two 64-bit sign-extended lanes).
REQ-002 Parameter N_CH, default 4: number of upstream DDC stream sources; legal range 2..8.
REQ-003 Parameter LEN_WIDTH, default 16: width of the burst length input.
REQ-004 aclk  input  1  single clock for all logic.
REQ-005 areset  input  1  reset, synchronous to aclk, active-high.
REQ-006 enable  input  1  permits new grants when high.
REQ-007 burst_len  input  LEN_WIDTH  beats per burst; sampled at grant.
REQ-008 s_axis_tdata  input  N_CH*DATA_WIDTH  source data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 s_axis_tvalid  input  N_CH  per-source valid.
REQ-010 s_axis_tready  output  N_CH  per-source ready.
REQ-011 m_axis_tdata  output  DATA_WIDTH  granted source data.
REQ-012 m_axis_tvalid  output  1  granted source valid.
REQ-013 m_axis_tready  input  1  downstream ready.
REQ-014 m_axis_tlast  output  1  final beat of a burst.
REQ-015 m_axis_tuser  output  3  granted channel index (present only under ARB_TUSER_EN).
REQ-016 busy  output  1  high in XFER.
REQ-017 grant_ch  output  3  index of the current or most recent grant.

Function
REQ-018 The FSM SHALL have two states, IDLE and XFER.
REQ-019 In IDLE with enable=1 and any s_axis_tvalid high, the block SHALL pick the first valid channel searching round-robin from (last_grant+1) mod N_CH, register grant_ch, latch burst_len, clear the beat counter, and enter XFER on the next cycle.
REQ-020 A latched burst_len of 0 SHALL be treated as 1.
REQ-021 In XFER, m_axis_tdata and m_axis_tvalid SHALL combinationally equal the granted source's data and valid, the granted s_axis_tready SHALL equal m_axis_tready, and every other s_axis_tready SHALL be 0.
REQ-022 In IDLE, all s_axis_tready, m_axis_tvalid and m_axis_tlast SHALL be 0.
REQ-023 The beat counter SHALL increment only on m_axis_tvalid && m_axis_tready.
REQ-024 m_axis_tlast SHALL be high when counter == latched_len-1 and the FSM is in XFER.
REQ-025 The handshake on the tlast beat SHALL return the FSM to IDLE, giving exactly one idle cycle between bursts.
REQ-026 A source stall (tvalid low) or a downstream stall (tready low) SHALL hold the counter and state indefinitely. There is no timeout.
REQ-027 If enable falls during XFER, the current burst SHALL complete and no new grant SHALL be issued.
REQ-028 Changes to burst_len during XFER SHALL NOT affect the active burst.
REQ-029 The channel granted last SHALL have the lowest priority at the next arbitration. A sole requesting channel SHALL be regranted back-to-back.

Reset
REQ-030 While areset=1, the state SHALL be IDLE, the counter 0, grant_ch N_CH-1 (so channel 0 wins the first arbitration), busy 0, and all ready, valid and last outputs 0.
REQ-031 Reset asserted mid-burst SHALL abort the burst on the next edge, with no tlast emitted.

Configuration
REQ-032 With macro ARB_TUSER_EN defined, m_axis_tuser SHALL exist and equal grant_ch during XFER and 0 in IDLE.
REQ-033 Without ARB_TUSER_EN, the m_axis_tuser port SHALL be absent and the remaining behaviour SHALL be unchanged.

Verification
REQ-034 The bench SHALL cover: all 4 channels continuously valid, burst_len=4, tready=1 -> grants 0,1,2,3,0, each 4 beats, tlast on beats 4/8/12/16, one idle cycle between bursts.
REQ-035 The bench SHALL cover: only channel 2 valid, burst_len=0 -> repeated 1-beat bursts from channel 2, tlast on every beat.
REQ-036 The bench SHALL cover: burst_len=8 with m_axis_tready toggling 1,0 each cycle -> 8 beats over 15 cycles, counter frozen while tready=0, data order preserved.
REQ-037 The bench SHALL cover: enable dropped after beat 2 of a 6-beat burst -> beats 3..6 still delivered with tlast on beat 6, then FSM idle with busy=0.
REQ-038 The bench SHALL cover: areset pulsed during beat 3 of 5 -> busy=0 and no tlast on the next cycle, and the next grant goes to channel 0.
REQ-039 The bench SHALL cover: with ARB_TUSER_EN, channels 1 and 3 valid -> m_axis_tuser alternates 1,3 across bursts; without ARB_TUSER_EN, the design compiles with no tuser port.

Source files
------------

// File: rtl/ddc_stream_arbiter_if.sv
// rtl/ddc_stream_arbiter_if.sv - stream bundle for ddc_stream_arbiter (m_axis_tuser only under ARB_TUSER_EN)
// master = arbiter side, slave = sources/sink side.
interface ddc_stream_arbiter_if #(
    parameter int DATA_WIDTH = 128,
    parameter int N_CH       = 4
);
    logic [N_CH*DATA_WIDTH-1:0] s_axis_tdata;
    logic [N_CH-1:0]            s_axis_tvalid;
    logic [N_CH-1:0]            s_axis_tready;
    logic [DATA_WIDTH-1:0]      m_axis_tdata;
    logic                       m_axis_tvalid;
    logic                       m_axis_tready;
    logic                       m_axis_tlast;
`ifdef ARB_TUSER_EN
    logic [2:0]                 m_axis_tuser;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
    modport slave (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
`else
    modport master (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
    modport slave (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
`endif
endinterface

// File: rtl/ddc_stream_arbiter.sv
// rtl/ddc_stream_arbiter.sv - round-robin burst arbiter for DDC IQ streams; ARB_TUSER_EN adds m_axis_tuser
module ddc_stream_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int N_CH       = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 enable,
    input  logic [LEN_WIDTH-1:0] burst_len,
    ddc_stream_arbiter_if.master bus,
    output logic                 busy,
    output logic [2:0]           grant_ch
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [7:0]            valid_pad;
    logic [7:0]            ready_pad;
    logic [DATA_WIDTH-1:0] lane [8];
    logic [2:0]            pick;
    logic [2:0]            rr_idx;
    logic                  pick_ok;
    logic                  last_beat;
    logic                  hs;

    // Pad per-channel vectors to 8 so a 3-bit channel index always selects in range.
    assign valid_pad = 8'(bus.s_axis_tvalid);

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_lane
            if (g < N_CH) begin : g_used
                assign lane[g] = bus.s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_unused
                assign lane[g] = '0;
            end
        end
    endgenerate

    // Search starts just after the last grant, so that channel ends up lowest priority.
    always_comb begin
        pick    = grant_ch;
        pick_ok = 1'b0;
        rr_idx  = 3'd0;
        for (int i = 1; i <= N_CH; i++) begin
            rr_idx = 3'((int'(grant_ch) + i) % N_CH);
            if (!pick_ok && valid_pad[rr_idx]) begin
                pick    = rr_idx;
                pick_ok = 1'b1;
            end
        end
    end

    assign last_beat = (beat_cnt == len_q - LEN_WIDTH'(1));

    always_comb begin
        ready_pad          = '0;
        bus.m_axis_tvalid  = 1'b0;
        bus.m_axis_tdata   = '0;
        bus.m_axis_tlast   = 1'b0;
        if (state == XFER) begin
            ready_pad[grant_ch] = bus.m_axis_tready;
            bus.m_axis_tvalid   = valid_pad[grant_ch];
            bus.m_axis_tdata    = lane[grant_ch];
            bus.m_axis_tlast    = last_beat;
        end
    end

    assign bus.s_axis_tready = ready_pad[N_CH-1:0];
    assign hs = bus.m_axis_tvalid & bus.m_axis_tready;

`ifdef ARB_TUSER_EN
    assign bus.m_axis_tuser = (state == XFER) ? grant_ch : 3'd0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            len_q    <= LEN_WIDTH'(1);
            grant_ch <= 3'(N_CH - 1);
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && pick_ok) begin
                        grant_ch <= pick;
                        len_q    <= (burst_len == '0) ? LEN_WIDTH'(1) : burst_len;
                        beat_cnt <= '0;
                        state    <= XFER;
                        busy     <= 1'b1;
                    end
                end
                XFER: begin
                    if (hs) begin
                        if (last_beat) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ddc_stream_arbiter.sv
// tb/tb_ddc_stream_arbiter.sv - self-checking bench for ddc_stream_arbiter
module tb_ddc_stream_arbiter;
    localparam int DW = 128;
    localparam int NC = 4;
    localparam int LW = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic          enable;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic [2:0]    grant_ch;

    ddc_stream_arbiter_if #(.DATA_WIDTH(DW), .N_CH(NC)) bus ();

    ddc_stream_arbiter #(.DATA_WIDTH(DW), .N_CH(NC), .LEN_WIDTH(LW)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .enable    (enable),
        .burst_len (burst_len),
        .bus       (bus),
        .busy      (busy),
        .grant_ch  (grant_ch)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int ch;
        int seq;
        bit last;
        int cyc;
    } beat_t;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    src_seq [NC];
    beat_t q [$];

    // Reference model: busy flag, channel, beats remaining.
    bit mod_live = 1'b0;
    bit mod_busy = 1'b0;
    int mod_ch   = NC - 1;
    int mod_left = 0;

    bit            sn_rst = 1'b0, sn_en = 1'b0, sn_mod_hs = 1'b0, sn_dut_hs = 1'b0, sn_dut_last = 1'b0;
    logic [NC-1:0] sn_valid = '0, sn_ready = '0;
    int            sn_len = 0, sn_dut_ch = 0, sn_dut_seq = 0;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] lane_val(input int ch);
        return {32'(ch), 64'h0, 32'(src_seq[ch])};
    endfunction

    function automatic int rr_pick(input logic [NC-1:0] v, input int last);
        int best, bestd, d;
        best  = -1;
        bestd = NC;
        for (int k = 0; k < NC; k++) begin
            d = (k - last - 1 + 2 * NC) % NC;
            if (v[k] && d < bestd) begin
                bestd = d;
                best  = k;
            end
        end
        return best;
    endfunction

    always @(negedge aclk) begin
        logic [NC-1:0] exp_ready;
        bit            exp_valid;
        sn_rst      = areset;
        sn_en       = enable;
        sn_valid    = bus.s_axis_tvalid;
        sn_ready    = bus.s_axis_tready;
        sn_len      = int'(burst_len);
        sn_dut_hs   = bus.m_axis_tvalid && bus.m_axis_tready && !areset;
        sn_dut_last = bus.m_axis_tlast;
        sn_dut_ch   = int'(bus.m_axis_tdata[127:96]);
        sn_dut_seq  = int'(bus.m_axis_tdata[31:0]);
        exp_valid   = mod_busy && bus.s_axis_tvalid[mod_ch];
        sn_mod_hs   = exp_valid && bus.m_axis_tready;
        exp_ready   = '0;
        if (mod_busy) exp_ready[mod_ch] = bus.m_axis_tready;
        if (mod_live) begin
            check("busy", 128'(busy), 128'(mod_busy));
            check("grant_ch", 128'(grant_ch), 128'(mod_ch));
            check("s_tready", 128'(bus.s_axis_tready), 128'(exp_ready));
            check("m_tvalid", 128'(bus.m_axis_tvalid), 128'(exp_valid));
            check("m_tlast", 128'(bus.m_axis_tlast), 128'(mod_busy && mod_left == 1));
            if (exp_valid) check("m_tdata", bus.m_axis_tdata, lane_val(mod_ch));
`ifdef ARB_TUSER_EN
            check("m_tuser", 128'(bus.m_axis_tuser), 128'(mod_busy ? mod_ch : 0));
`endif
        end
    end

    always @(posedge aclk) begin
        beat_t b;
        cyc++;
        if (sn_rst) begin
            mod_live = 1'b1;
            mod_busy = 1'b0;
            mod_ch   = NC - 1;
            mod_left = 0;
            for (int k = 0; k < NC; k++) src_seq[k] = 0;
        end else if (mod_live) begin
            if (sn_dut_hs) begin
                b.ch   = sn_dut_ch;
                b.seq  = sn_dut_seq;
                b.last = sn_dut_last;
                b.cyc  = cyc;
                q.push_back(b);
            end
            for (int k = 0; k < NC; k++)
                if (sn_ready[k] && sn_valid[k]) src_seq[k]++;
            if (!mod_busy) begin
                if (sn_en && sn_valid != '0) begin
                    mod_ch   = rr_pick(sn_valid, mod_ch);
                    mod_left = (sn_len == 0) ? 1 : sn_len;
                    mod_busy = 1'b1;
                end
            end else if (sn_mod_hs) begin
                mod_left--;
                if (mod_left == 0) mod_busy = 1'b0;
            end
        end
        for (int k = 0; k < NC; k++) bus.s_axis_tdata[k*DW +: DW] = lane_val(k);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick(2);
        areset = 1'b0;
        q.delete();
    endtask

    task automatic wait_beats(input string nm, input int n, input int budget);
        int b;
        b = budget;
        while (q.size() < n && b > 0) begin
            tick(1);
            b--;
        end
        check(nm, 128'(q.size()), 128'(n));
    endtask

    initial begin
        int exp_ch [8];
        areset = 1'b1; enable = 1'b0; burst_len = '0;
        bus.s_axis_tvalid = '0; bus.m_axis_tready = 1'b0;
        tick(3);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_grant", 128'(grant_ch), 128'(NC - 1));
        check("rst_tvalid", 128'(bus.m_axis_tvalid), 128'(0));
        check("rst_tlast", 128'(bus.m_axis_tlast), 128'(0));
        check("rst_tready", 128'(bus.s_axis_tready), 128'(0));
        areset = 1'b0;
        q.delete();

        // All channels valid, 4-beat bursts.
        enable = 1'b1; burst_len = 16'd4; bus.s_axis_tvalid = 4'hF; bus.m_axis_tready = 1'b1;
        wait_beats("t1_beats", 20, 200);
        bus.s_axis_tvalid = '0;
        if (q.size() >= 20) begin
            for (int i = 0; i < 20; i++) begin
                check("t1_ch", 128'(q[i].ch), 128'((i / 4) % 4));
                check("t1_seq", 128'(q[i].seq), 128'((i < 16) ? i % 4 : 4 + i % 4));
                check("t1_last", 128'(q[i].last), 128'(i % 4 == 3));
            end
            for (int b = 1; b < 5; b++)
                check("t1_gap", 128'(q[4*b].cyc - q[4*b-1].cyc), 128'(2));
        end

        // Sole requester with burst_len 0.
        do_reset();
        burst_len = 16'd0; bus.s_axis_tvalid = 4'b0100; bus.m_axis_tready = 1'b1;
        wait_beats("t2_beats", 4, 50);
        bus.s_axis_tvalid = '0;
        if (q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_ch", 128'(q[i].ch), 128'(2));
                check("t2_seq", 128'(q[i].seq), 128'(i));
                check("t2_last", 128'(q[i].last), 128'(1));
                if (i > 0) check("t2_gap", 128'(q[i].cyc - q[i-1].cyc), 128'(2));
            end
        end

        // Downstream ready toggling.
        do_reset();
        burst_len = 16'd8; bus.m_axis_tready = 1'b0; bus.s_axis_tvalid = 4'b0001;
        begin
            int b;
            b = 20;
            while (!busy && b > 0) begin tick(1); b--; end
            check("t3_busy", 128'(busy), 128'(1));
        end
        for (int i = 0; i < 15; i++) begin
            bus.m_axis_tready = (i % 2 == 0);
            tick(1);
        end
        bus.s_axis_tvalid = '0; bus.m_axis_tready = 1'b1;
        check("t3_beats", 128'(q.size()), 128'(8));
        if (q.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                check("t3_seq", 128'(q[i].seq), 128'(i));
                check("t3_last", 128'(q[i].last), 128'(i == 7));
            end
            check("t3_span", 128'(q[7].cyc - q[0].cyc), 128'(14));
        end

        // Enable dropped mid-burst.
        do_reset();
        enable = 1'b1; burst_len = 16'd6; bus.s_axis_tvalid = 4'b0001; bus.m_axis_tready = 1'b1;
        wait_beats("t4_two", 2, 30);
        enable = 1'b0;
        wait_beats("t4_six", 6, 30);
        tick(4);
        check("t4_nogrant", 128'(q.size()), 128'(6));
        check("t4_busy", 128'(busy), 128'(0));
        if (q.size() >= 6)
            for (int i = 0; i < 6; i++) check("t4_last", 128'(q[i].last), 128'(i == 5));
        bus.s_axis_tvalid = '0; enable = 1'b1;

        // Reset during beat 3 of 5.
        do_reset();
        burst_len = 16'd5; bus.s_axis_tvalid = 4'b0001; bus.m_axis_tready = 1'b1;
        wait_beats("t5_two", 2, 30);
        areset = 1'b1;
        tick(1);
        areset = 1'b0;
        bus.s_axis_tvalid = 4'b0011;
        check("t5_busy", 128'(busy), 128'(0));
        check("t5_tlast", 128'(bus.m_axis_tlast), 128'(0));
        check("t5_count", 128'(q.size()), 128'(2));
        tick(1);
        check("t5_grant", 128'(grant_ch), 128'(0));
        check("t5_busy2", 128'(busy), 128'(1));
        wait_beats("t5_beats", 7, 30);
        if (q.size() >= 7) check("t5_ch", 128'(q[2].ch), 128'(0));
        bus.s_axis_tvalid = '0;

        // Channels 1 and 3 alternate.
        do_reset();
        burst_len = 16'd2; bus.s_axis_tvalid = 4'b1010; bus.m_axis_tready = 1'b1;
        exp_ch = '{1, 1, 3, 3, 1, 1, 3, 3};
        wait_beats("t6_beats", 8, 60);
        bus.s_axis_tvalid = '0;
        if (q.size() >= 8)
            for (int i = 0; i < 8; i++) check("t6_ch", 128'(q[i].ch), 128'(exp_ch[i]));
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
